// File: rtl/mem_pkg.sv
// Shared encodings, FSM state type and bus payload for the memory arbiter.
package mem_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned OP_W   = 2;
  localparam int unsigned SIZE_W = 2;
  localparam int unsigned WAIT_W = 8;

  typedef enum logic [OP_W-1:0] {
    MEM_DISABLE   = 2'b00,
    MEM_READ_SEXT = 2'b01,
    MEM_READ_ZEXT = 2'b10,
    MEM_WRITE     = 2'b11
  } mem_op_e;

  typedef enum logic [SIZE_W-1:0] {
    BYTE     = 2'b00,
    HALFWORD = 2'b01,
    WORD     = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    RESP  = 2'b10
  } arb_state_e;

  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    mem_op_e         op;
    mem_size_e       size;
  } mem_cmd_t;

  // True when the address is not naturally aligned for the access size.
  function automatic logic misaligned(input logic [SIZE_W-1:0] size, input logic [1:0] addr_lo);
    case (size)
      HALFWORD: return addr_lo[0];
      WORD:     return addr_lo != 2'b00;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and backend signals of the memory arbiter; slave = arbiter view.
interface mem_arbiter_if;
  import mem_pkg::*;

  logic              if_req;
  logic [XLEN-1:0]   if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [XLEN-1:0]   if_rdata;
  logic              d_req;
  logic [XLEN-1:0]   d_addr;
  logic [XLEN-1:0]   d_wdata;
  logic [OP_W-1:0]   d_op;
  logic [SIZE_W-1:0] d_size;
  logic              d_gnt;
  logic              d_rvalid;
  logic [XLEN-1:0]   d_rdata;
  logic              d_fault;
  logic              mem_req;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [OP_W-1:0]   mem_op;
  logic [SIZE_W-1:0] mem_size;
  logic [XLEN-1:0]   mem_rdata;
  logic              mem_ready;

  modport slave (
    input  if_req, if_addr, d_req, d_addr, d_wdata, d_op, d_size, mem_rdata, mem_ready,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_fault,
           mem_req, mem_addr, mem_wdata, mem_op, mem_size
  );

  modport master (
    output if_req, if_addr, d_req, d_addr, d_wdata, d_op, d_size, mem_rdata, mem_ready,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_fault,
           mem_req, mem_addr, mem_wdata, mem_op, mem_size
  );

endinterface

// File: rtl/mem_arb_prio.sv
// Data-over-fetch priority with a bounded data streak so fetches cannot starve.
module mem_arb_prio #(
  parameter int unsigned DSTREAK_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample,
  input  logic if_req,
  input  logic d_valid,
  output logic grant_if_c,
  output logic grant_d_c
);

  localparam int unsigned STREAK_W = (DSTREAK_MAX < 1) ? 1 : $clog2(DSTREAK_MAX + 1);
  localparam logic [STREAK_W-1:0] STREAK_SAT = STREAK_W'(DSTREAK_MAX);

  logic [STREAK_W-1:0] streak_q, streak_d;

  always_comb begin
    grant_if_c = 1'b0;
    grant_d_c  = 1'b0;
    streak_d   = streak_q;
    if (sample) begin
      if (if_req && (!d_valid || streak_q == STREAK_SAT)) grant_if_c = 1'b1;
      else if (d_valid)                                   grant_d_c  = 1'b1;
    end
    // The streak only means something while a fetch is actually waiting.
    if (!if_req || grant_if_c)                   streak_d = '0;
    else if (grant_d_c && streak_q != STREAK_SAT) streak_d = streak_q + STREAK_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) streak_q <= '0;
    else        streak_q <= streak_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) memory arbiter, one access outstanding, with timeout.
// Optional build macro MEM_ALIGN_CHECK_EN faults misaligned data requests without issuing them.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned DSTREAK_MAX = 4,
  parameter int unsigned TIMEOUT     = 255
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  arb_state_e        state_q, state_d;
  mem_cmd_t          cmd_q, cmd_d;
  logic              mem_req_q, mem_req_d;
  logic              is_data_q, is_data_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              if_gnt_q, if_gnt_d, d_gnt_q, d_gnt_d;
  logic              if_rvalid_q, if_rvalid_d, d_rvalid_q, d_rvalid_d;
  logic [XLEN-1:0]   if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic              d_fault_q, d_fault_d;

  logic d_valid_c, grant_if_c, grant_d_c;

  assign d_valid_c = bus.d_req && (bus.d_op != MEM_DISABLE);

  mem_arb_prio #(.DSTREAK_MAX(DSTREAK_MAX)) u_prio (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample     (state_q == IDLE),
    .if_req     (bus.if_req),
    .d_valid    (d_valid_c),
    .grant_if_c (grant_if_c),
    .grant_d_c  (grant_d_c)
  );

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    mem_req_d   = mem_req_q;
    is_data_d   = is_data_q;
    wait_d      = wait_q;
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    d_fault_d   = 1'b0;

    case (state_q)
      IDLE: begin
        wait_d = '0;
        if (grant_if_c) begin
          if_gnt_d  = 1'b1;
          is_data_d = 1'b0;
          cmd_d     = '{addr: bus.if_addr, wdata: '0, op: MEM_READ_ZEXT, size: WORD};
          mem_req_d = 1'b1;
          state_d   = ISSUE;
        end else if (grant_d_c) begin
          d_gnt_d   = 1'b1;
          is_data_d = 1'b1;
          cmd_d     = '{addr: bus.d_addr, wdata: bus.d_wdata,
                        op: mem_op_e'(bus.d_op), size: mem_size_e'(bus.d_size)};
`ifdef MEM_ALIGN_CHECK_EN
          if (misaligned(bus.d_size, bus.d_addr[1:0])) begin
            cmd_d      = '0;
            d_rvalid_d = 1'b1;
            d_rdata_d  = '0;
            d_fault_d  = 1'b1;
            state_d    = RESP;
          end else begin
            mem_req_d = 1'b1;
            state_d   = ISSUE;
          end
`else
          mem_req_d = 1'b1;
          state_d   = ISSUE;
`endif
        end
      end

      ISSUE: begin
        // mem_ready wins over an expiring wait counter.
        if (bus.mem_ready || wait_q == WAIT_LAST) begin
          mem_req_d = 1'b0;
          cmd_d     = '0;
          state_d   = RESP;
          if (is_data_q) begin
            d_rvalid_d = 1'b1;
            d_fault_d  = !bus.mem_ready;
            d_rdata_d  = (bus.mem_ready && cmd_q.op != MEM_WRITE) ? bus.mem_rdata : '0;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = bus.mem_ready ? bus.mem_rdata : NOP;
          end
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      RESP: begin
        wait_d  = '0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      mem_req_q   <= 1'b0;
      is_data_q   <= 1'b0;
      wait_q      <= '0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      d_fault_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      mem_req_q   <= mem_req_d;
      is_data_q   <= is_data_d;
      wait_q      <= wait_d;
      if_gnt_q    <= if_gnt_d;
      d_gnt_q     <= d_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      d_fault_q   <= d_fault_d;
    end
  end

  assign bus.if_gnt    = if_gnt_q;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_gnt     = d_gnt_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_fault   = d_fault_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = cmd_q.addr;
  assign bus.mem_wdata = cmd_q.wdata;
  assign bus.mem_op    = cmd_q.op;
  assign bus.mem_size  = cmd_q.size;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table, multi-cycle sequences, random traffic.
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int unsigned DSTREAK = 4;
  localparam int unsigned TMO     = 255;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter #(.DSTREAK_MAX(DSTREAK), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] mem_model [logic [31:0]];

  typedef struct {
    logic        fr;
    logic [31:0] fa;
    logic        dr;
    logic [1:0]  op;
    logic [1:0]  sz;
    logic [31:0] da;
    logic [31:0] wd;
    int          delay;
    logic        exp_d;
    logic        exp_issue;
    logic [31:0] exp_rdata;
    logic        exp_fault;
  } vec_t;

  vec_t vecs [12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem_model.exists(a) ? mem_model[a] : ~a;
  endfunction

  function automatic logic [159:0] outs();
    return 160'({bus.if_gnt, bus.if_rvalid, bus.if_rdata, bus.d_gnt, bus.d_rvalid, bus.d_rdata,
                 bus.d_fault, bus.mem_req, bus.mem_addr, bus.mem_wdata, bus.mem_op, bus.mem_size});
  endfunction

  function automatic logic [159:0] issue_bus();
    return 160'({bus.mem_req, bus.mem_addr, bus.mem_wdata, bus.mem_op, bus.mem_size});
  endfunction

  // One transaction from an IDLE cycle: grant, backend access (delay<0 = never ready), response.
  task automatic run_txn(input string nm, input logic fr, input logic [31:0] fa, input logic dr,
                         input logic [1:0] op, input logic [1:0] sz, input logic [31:0] da,
                         input logic [31:0] wd, input int delay, input logic rel, input logic exp_d,
                         input logic exp_issue, input logic [31:0] exp_rdata, input logic exp_fault);
    int cyc;
    logic [31:0] ea, ewd, rsel;
    logic [1:0]  eop, esz;
    bus.if_req = fr; bus.if_addr = fa;
    bus.d_req = dr; bus.d_op = op; bus.d_size = sz; bus.d_addr = da; bus.d_wdata = wd;
    bus.mem_ready = 1'b0;
    cyc = 0;
    do begin step(); cyc++; end while (!(bus.if_gnt || bus.d_gnt) && cyc < 4);
    chk({nm, " gnt"}, 160'({bus.if_gnt, bus.d_gnt}), 160'(exp_d ? 2'b01 : 2'b10));
    chk({nm, " gnt_latency"}, 160'(cyc), 160'(1));
    if (rel) begin
      if (exp_d) begin
        bus.d_req = 1'b0; bus.d_addr = ~da; bus.d_wdata = ~wd; bus.d_op = ~op; bus.d_size = ~sz;
      end else begin
        bus.if_req = 1'b0; bus.if_addr = ~fa;
      end
    end
    ea  = exp_d ? da : fa;
    ewd = exp_d ? wd : 32'h0;
    eop = exp_d ? op : 2'(MEM_READ_ZEXT);
    esz = exp_d ? sz : 2'(WORD);
    if (exp_issue) begin
      chk({nm, " issue"}, issue_bus(), 160'({1'b1, ea, ewd, eop, esz}));
      if (delay >= 0) begin
        for (int i = 0; i < delay; i++) begin
          step();
          chk({nm, " hold"}, issue_bus(), 160'({1'b1, ea, ewd, eop, esz}));
        end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = (eop == 2'(MEM_WRITE)) ? $urandom() : mem_rd(ea);
        if (eop == 2'(MEM_WRITE)) mem_model[ea] = ewd;
        step();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = $urandom();
      end else begin
        cyc = 1;
        do begin step(); cyc++; end while (bus.mem_req && cyc < int'(TMO) + 4);
        chk({nm, " timeout_cycle"}, 160'(cyc), 160'(TMO + 1));
      end
    end
    rsel = exp_d ? bus.d_rdata : bus.if_rdata;
    chk({nm, " resp"}, 160'({bus.if_rvalid, bus.d_rvalid, rsel, bus.d_fault, bus.mem_req}),
        160'({~exp_d, exp_d, exp_rdata, exp_fault, 1'b0}));
    step();
    chk({nm, " rvalid_pulse"}, 160'({bus.if_rvalid, bus.d_rvalid, bus.d_fault}), 160'(0));
  endtask

  task automatic gap();
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    step();
    chk("no_req_no_gnt", 160'({bus.if_gnt, bus.d_gnt, bus.mem_req}), 160'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic        f_p, d_p, dv, fwin;
    logic [31:0] f_a, d_a, d_w, exp;
    logic [1:0]  d_o, d_s;
    int          streak;

    vecs[0]  = '{1'b0, 32'h0, 1'b1, MEM_WRITE, WORD, 32'h8000_0000, 32'hdead_beef, 0, 1'b1, 1'b1, 32'h0, 1'b0};
    vecs[1]  = '{1'b0, 32'h0, 1'b1, MEM_READ_ZEXT, WORD, 32'h8000_0000, 32'h0, 0, 1'b1, 1'b1, 32'hdead_beef, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_1000, 1'b0, MEM_DISABLE, WORD, 32'h0, 32'h0, 2, 1'b0, 1'b1, 32'hffff_efff, 1'b0};
    vecs[3]  = '{1'b1, 32'h0000_2000, 1'b1, MEM_DISABLE, WORD, 32'h8000_0000, 32'h0, 0, 1'b0, 1'b1, 32'hffff_dfff, 1'b0};
`ifdef MEM_ALIGN_CHECK_EN
    vecs[4]  = '{1'b0, 32'h0, 1'b1, MEM_READ_SEXT, HALFWORD, 32'h8000_0001, 32'h0, 1, 1'b1, 1'b0, 32'h0, 1'b1};
`else
    vecs[4]  = '{1'b0, 32'h0, 1'b1, MEM_READ_SEXT, HALFWORD, 32'h8000_0001, 32'h0, 1, 1'b1, 1'b1, 32'h7fff_fffe, 1'b0};
`endif
    vecs[5]  = '{1'b0, 32'h0, 1'b1, MEM_READ_ZEXT, WORD, 32'h9000_0000, 32'h0, -1, 1'b1, 1'b1, 32'h0, 1'b1};
    vecs[6]  = '{1'b1, 32'h0000_3000, 1'b0, MEM_DISABLE, WORD, 32'h0, 32'h0, -1, 1'b0, 1'b1, 32'h0000_0013, 1'b0};
    vecs[7]  = '{1'b0, 32'h0, 1'b1, MEM_WRITE, BYTE, 32'h8000_0004, 32'h0000_00a5, 3, 1'b1, 1'b1, 32'h0, 1'b0};
    vecs[8]  = '{1'b0, 32'h0, 1'b1, MEM_READ_ZEXT, BYTE, 32'h8000_0004, 32'h0, 0, 1'b1, 1'b1, 32'h0000_00a5, 1'b0};
    vecs[9]  = '{1'b1, 32'h0000_4000, 1'b1, MEM_READ_ZEXT, WORD, 32'h8000_0000, 32'h0, 1, 1'b1, 1'b1, 32'hdead_beef, 1'b0};
    vecs[10] = '{1'b0, 32'h0, 1'b1, MEM_READ_SEXT, HALFWORD, 32'h8000_0002, 32'h0, 0, 1'b1, 1'b1, 32'h7fff_fffd, 1'b0};
    vecs[11] = '{1'b1, 32'h0000_0000, 1'b0, MEM_DISABLE, WORD, 32'h0, 32'h0, 1, 1'b0, 1'b1, 32'hffff_ffff, 1'b0};

    rst_n = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0; bus.d_req = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.d_op = '0; bus.d_size = '0; bus.mem_rdata = '0; bus.mem_ready = 1'b0;
    #12;
    chk("reset_outputs", outs(), 160'(0));
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 12; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].fr, vecs[i].fa, vecs[i].dr, vecs[i].op, vecs[i].sz,
              vecs[i].da, vecs[i].wd, vecs[i].delay, 1'b1, vecs[i].exp_d, vecs[i].exp_issue,
              vecs[i].exp_rdata, vecs[i].exp_fault);
      gap();
    end

    // Both requesters held high: four data grants, then the fetch.
    for (int i = 0; i < 10; i++) begin
      run_txn($sformatf("streak%0d", i), 1'b1, 32'h0000_5000, 1'b1, MEM_READ_ZEXT, WORD,
              32'h8000_0000, 32'h0, 0, 1'b0, (i % 5) != 4, 1'b1,
              ((i % 5) != 4) ? 32'hdead_beef : 32'hffff_afff, 1'b0);
    end
    gap();

    // Reset in the middle of an access, then a stray mem_ready.
    bus.d_req = 1'b1; bus.d_op = MEM_READ_ZEXT; bus.d_size = WORD; bus.d_addr = 32'h8000_0000;
    step();
    chk("rst_mid gnt", 160'(bus.d_gnt), 160'(1));
    bus.d_req = 1'b0;
    step();
    chk("rst_mid issue", 160'(bus.mem_req), 160'(1));
    rst_n = 1'b0;
    #1;
    chk("rst_mid outputs", outs(), 160'(0));
    step();
    chk("rst_mid held", outs(), 160'(0));
    rst_n = 1'b1;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h1234_5678;
    step();
    bus.mem_ready = 1'b0;
    chk("rst_mid stray_ready", outs(), 160'(0));
    step();
    chk("rst_mid no_rvalid", outs(), 160'(0));
    run_txn("post_rst", 1'b0, 32'h0, 1'b1, MEM_READ_ZEXT, WORD, 32'h8000_0000, 32'h0, 0, 1'b1,
            1'b1, 1'b1, 32'hdead_beef, 1'b0);
    gap();

    // Random traffic: each requester holds its request until granted.
    f_p = 1'b0; d_p = 1'b0; streak = 0;
    f_a = '0; d_a = '0; d_w = '0; d_o = '0; d_s = '0;
    for (int t = 0; t < 150; t++) begin
      if (!f_p) begin
        f_p = ($urandom_range(0, 2) != 0);
        f_a = $urandom() & 32'hffff_fffc;
      end
      if (!d_p || d_o == 2'(MEM_DISABLE)) begin
        d_p = ($urandom_range(0, 2) != 0);
        d_o = 2'($urandom_range(0, 3));
        d_s = 2'($urandom_range(0, 2));
        d_a = 32'h8000_0000 + 32'($urandom_range(0, 7)) * 32'd4;
        d_w = $urandom();
      end
      dv = d_p && (d_o != 2'(MEM_DISABLE));
      if (!f_p && !dv) begin
        bus.if_req = 1'b0; bus.d_req = d_p; bus.d_op = d_o;
        step();
        chk("rnd no_gnt", 160'({bus.if_gnt, bus.d_gnt}), 160'(0));
        streak = 0;
      end else begin
        fwin = f_p && (!dv || streak == int'(DSTREAK));
        exp  = fwin ? mem_rd(f_a) : ((d_o == 2'(MEM_WRITE)) ? 32'h0 : mem_rd(d_a));
        run_txn($sformatf("rnd%0d", t), f_p, f_a, d_p, d_o, d_s, d_a, d_w,
                int'($urandom_range(0, 3)), 1'b1, !fwin, 1'b1, exp, 1'b0);
        if (fwin) begin
          streak = 0;
          f_p = 1'b0;
        end else begin
          streak = f_p ? ((streak < int'(DSTREAK)) ? streak + 1 : int'(DSTREAK)) : 0;
          d_p = 1'b0;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
